bayer_demosaic_stream: RTL and testbench

Parametrised raw-Bayer to RGB converter for the camera capture path. It takes a pixel stream that is already synchronous to Clock_50, with per-pixel valid strobes and frame/line qualifiers. It emits one RGB pixel per 2x2 Bayer quad. Compared with the fixed camera data controller, it adds configurable data width and line depth, a runtime-selectable Bayer pattern, single-shot and continuous capture with graceful stop, line-overflow detection, and status outputs.

---
 rtl/bayer_demosaic_stream_pkg.sv | 27 ++
 rtl/bayer_demosaic_stream_if.sv | 26 ++
 rtl/bayer_demosaic_stream_line_buffer_ram.sv | 22 ++
 rtl/bayer_demosaic_stream.sv | 162 ++++++++++++++++
 tb/tb_bayer_demosaic_stream.sv | 318 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bayer_demosaic_stream_pkg.sv
// Shared types and sizing helpers for the raw-Bayer to RGB stream converter.
package bayer_pkg;

   typedef enum logic [1:0] {
      RGGB = 2'd0,
      GRBG = 2'd1,
      GBRG = 2'd2,
      BGGR = 2'd3
   } bayer_pattern_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } capture_state_t;

   localparam int DATA_WIDTH_DEFAULT = 10;
   localparam int LINE_WIDTH_DEFAULT = 1280;

   // The column counter must also hold LINE_WIDTH itself to flag overflow.
   function automatic int col_width(input int line_width);
      return $clog2(line_width + 1);
   endfunction

   localparam int COL_W_DEFAULT = col_width(LINE_WIDTH_DEFAULT);

endpackage

// File: rtl/bayer_demosaic_stream_if.sv
// Pixel-stream bundle: raw samples in, demosaiced RGB out.
interface bayer_demosaic_stream_if #(
   parameter int DATA_WIDTH = 10
);
   // No backpressure: iData is taken in any cycle where iData_Valid and
   // iLine_Valid are both high, and oRed/oGreen/oBlue are new exactly in
   // cycles where oData_Valid is high (they hold their value otherwise).
   logic [DATA_WIDTH-1:0] iData;
   logic                  iData_Valid;
   logic                  iFrame_Valid;
   logic                  iLine_Valid;
   logic [DATA_WIDTH-1:0] oRed;
   logic [DATA_WIDTH-1:0] oGreen;
   logic [DATA_WIDTH-1:0] oBlue;
   logic                  oData_Valid;

   modport master (
      output iData, iData_Valid, iFrame_Valid, iLine_Valid,
      input  oRed, oGreen, oBlue, oData_Valid
   );

   modport slave (
      input  iData, iData_Valid, iFrame_Valid, iLine_Valid,
      output oRed, oGreen, oBlue, oData_Valid
   );
endinterface

// File: rtl/bayer_demosaic_stream_line_buffer_ram.sv
// Simple dual-port line store: one write port, one registered read port.
module line_buffer_ram #(
   parameter int DATA_WIDTH = 10,
   parameter int DEPTH      = 1280,
   parameter int ADDR_W     = 11
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/bayer_demosaic_stream.sv
// Raw-Bayer to RGB converter: one RGB pixel per 2x2 quad, with frame-level
// capture control (single-shot / continuous, graceful stop) and status.
module bayer_demosaic_stream
   import bayer_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
   parameter int LINE_WIDTH = LINE_WIDTH_DEFAULT
) (
   input  logic                   Clock_50,
   input  logic                   Reset,
   input  logic                   Enable,
   input  logic                   Start,
   input  logic                   Stop,
   input  logic                   Single_Shot,
   input  logic [1:0]             iPattern,
   bayer_demosaic_stream_if.slave pix,
   output logic                   oFrame_Start,
   output logic [31:0]            oFrame_Count,
   output logic                   oOverflow,
   output logic                   oBusy,
   output capture_state_t         state_dbg
);

   localparam int X_W = col_width(LINE_WIDTH);
   localparam int A_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;

   capture_state_t state, state_nx;
   logic           accept_frame;

   logic           fv_q, lv_q;
   logic           frame_rise, frame_fall, line_fall;
   logic           stop_pending;
   bayer_pattern_t pattern_q;
   logic [X_W-1:0] x;
   logic           row_odd;
   logic           pix_accept, in_range, wr_en;

   logic                  s1_valid, s1_odd;
   logic [DATA_WIDTH-1:0] tl, tr, bl, br;
   logic [DATA_WIDTH:0]   sum_a, sum_b;
   logic [DATA_WIDTH-1:0] red_nx, green_nx, blue_nx;

   assign frame_rise = pix.iFrame_Valid & ~fv_q;
   assign frame_fall = ~pix.iFrame_Valid & fv_q;
   assign line_fall  = ~pix.iLine_Valid & lv_q;
   assign pix_accept = (state == CAPTURE) & pix.iData_Valid & pix.iLine_Valid;
   assign in_range   = (x < X_W'(LINE_WIDTH));
   assign wr_en      = pix_accept & in_range & ~row_odd;
   assign oBusy      = (state != IDLE);
   assign state_dbg  = state;

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset)        state <= IDLE;
      else if (!Enable) state <= IDLE;
      else              state <= state_nx;
   end

   // Stop beats Start; a Stop seen during CAPTURE only counts at frame end.
   always_comb begin
      state_nx     = state;
      accept_frame = 1'b0;
      unique case (state)
         IDLE:    if (Start && !Stop) state_nx = ARMED;
         ARMED: begin
            if (Stop) begin
               state_nx = IDLE;
            end else if (frame_rise) begin
               state_nx     = CAPTURE;
               accept_frame = 1'b1;
            end
         end
         CAPTURE: if (frame_fall) state_nx = (Single_Shot || stop_pending || Stop) ? IDLE : ARMED;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         fv_q <= 1'b0; lv_q <= 1'b0; stop_pending <= 1'b0; pattern_q <= RGGB;
         x <= '0; row_odd <= 1'b0; oOverflow <= 1'b0; oFrame_Start <= 1'b0; oFrame_Count <= '0;
      end else if (!Enable) begin
         fv_q <= 1'b0; lv_q <= 1'b0; stop_pending <= 1'b0; pattern_q <= RGGB;
         x <= '0; row_odd <= 1'b0; oOverflow <= 1'b0; oFrame_Start <= 1'b0; oFrame_Count <= '0;
      end else begin
         fv_q         <= pix.iFrame_Valid;
         lv_q         <= pix.iLine_Valid;
         oFrame_Start <= accept_frame;
         if (state == CAPTURE) begin
            if (Stop) stop_pending <= 1'b1;
         end else begin
            stop_pending <= 1'b0;
         end
         if (accept_frame) begin
            oFrame_Count <= oFrame_Count + 32'd1;
            pattern_q    <= bayer_pattern_t'(iPattern);
            x            <= '0;
            row_odd      <= 1'b0;
         end else if (line_fall) begin
            x <= '0;
            if (state == CAPTURE) row_odd <= ~row_odd;
         end else if (pix_accept) begin
            // x saturates at LINE_WIDTH so the rest of an over-long line is dropped.
            if (in_range) x <= x + X_W'(1);
            else          oOverflow <= 1'b1;
         end
      end
   end

   line_buffer_ram #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (LINE_WIDTH),
      .ADDR_W    (A_W)
   ) u_line_buf (
      .clk    (Clock_50),
      .wr_en  (wr_en),
      .wr_addr(x[A_W-1:0]),
      .wr_data(pix.iData),
      .rd_addr(x[A_W-1:0]),
      .rd_data(tr)
   );

   // During the cycle after an odd-x pixel, tr is the buffered sample above it.
   always_comb begin
      sum_a    = {1'b0, tr} + {1'b0, bl};
      sum_b    = {1'b0, tl} + {1'b0, br};
      red_nx   = tl;
      blue_nx  = br;
      green_nx = DATA_WIDTH'(sum_a >> 1);
      unique case (pattern_q)
         RGGB: begin red_nx = tl; blue_nx = br; green_nx = DATA_WIDTH'(sum_a >> 1); end
         GRBG: begin red_nx = tr; blue_nx = bl; green_nx = DATA_WIDTH'(sum_b >> 1); end
         GBRG: begin red_nx = bl; blue_nx = tr; green_nx = DATA_WIDTH'(sum_b >> 1); end
         BGGR: begin red_nx = br; blue_nx = tl; green_nx = DATA_WIDTH'(sum_a >> 1); end
         default: ;
      endcase
   end

   always_ff @(posedge Clock_50 or posedge Reset) begin
      if (Reset) begin
         s1_valid <= 1'b0; s1_odd <= 1'b0; tl <= '0; bl <= '0; br <= '0;
         pix.oRed <= '0; pix.oGreen <= '0; pix.oBlue <= '0; pix.oData_Valid <= 1'b0;
      end else if (!Enable) begin
         s1_valid <= 1'b0; s1_odd <= 1'b0; tl <= '0; bl <= '0; br <= '0;
         pix.oRed <= '0; pix.oGreen <= '0; pix.oBlue <= '0; pix.oData_Valid <= 1'b0;
      end else begin
         s1_valid <= pix_accept & in_range & row_odd;
         s1_odd   <= x[0];
         if (pix_accept && in_range && row_odd) begin
            if (x[0]) br <= pix.iData;
            else      bl <= pix.iData;
         end
         if (s1_valid && !s1_odd) tl <= tr;
         pix.oData_Valid <= s1_valid & s1_odd;
         if (s1_valid && s1_odd) begin
            pix.oRed   <= red_nx;
            pix.oGreen <= green_nx;
            pix.oBlue  <= blue_nx;
         end
      end
   end

endmodule

// File: tb/tb_bayer_demosaic_stream.sv
// Bench for bayer_demosaic_stream: mapping table, capture-control sequences,
// overflow and reset corners, and random frames against a frame-level model.
module tb_bayer_demosaic_stream;
   import bayer_pkg::*;

   localparam int DW = 10;
   localparam int LW = 4;

   logic           clk = 1'b0;
   logic           rst, enable, start, stop, single_shot;
   logic [1:0]     pattern;
   logic           frame_start, overflow, busy;
   logic [31:0]    frame_count;
   capture_state_t state_dbg;

   bayer_demosaic_stream_if #(.DATA_WIDTH(DW)) pix ();

   bayer_demosaic_stream #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
      .Clock_50    (clk),
      .Reset       (rst),
      .Enable      (enable),
      .Start       (start),
      .Stop        (stop),
      .Single_Shot (single_shot),
      .iPattern    (pattern),
      .pix         (pix),
      .oFrame_Start(frame_start),
      .oFrame_Count(frame_count),
      .oOverflow   (overflow),
      .oBusy       (busy),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;
   int exp_count = 0;

   logic [3*DW-1:0] exp_q[$];
   int              lat_q[$];
   int              line_mem[LW];
   int              fr_pix[6][8];
   int              fr_len[6];
   int              fr_rows;

   typedef struct {
      int pat;
      int tl, tr, bl, br;
      int r, g, b;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (pix.oData_Valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got rgb %0h with nothing expected (cycle %0d)",
                     {pix.oRed, pix.oGreen, pix.oBlue}, cyc);
         end else begin
            check("rgb", {pix.oRed, pix.oGreen, pix.oBlue}, exp_q.pop_front());
         end
         if (lat_q.size() != 0) check("latency", cyc, lat_q.pop_front());
      end
   end

   // ---------------- reference model ----------------
   task automatic model_frame(input int pat, input bit push);
      int tl, tr, bl, br, r, g, b;
      for (int row = 0; row < fr_rows; row++) begin
         if (row % 2 == 0) begin
            for (int c = 0; c < fr_len[row] && c < LW; c++) line_mem[c] = fr_pix[row][c];
         end else begin
            for (int c = 1; c < fr_len[row] && c < LW; c += 2) begin
               tl = line_mem[c-1]; tr = line_mem[c];
               bl = fr_pix[row][c-1]; br = fr_pix[row][c];
               case (pat)
                  0:       begin r = tl; b = br; g = (tr + bl) / 2; end
                  1:       begin r = tr; b = bl; g = (tl + br) / 2; end
                  2:       begin r = bl; b = tr; g = (tl + br) / 2; end
                  default: begin r = br; b = tl; g = (tr + bl) / 2; end
               endcase
               if (push) exp_q.push_back({DW'(r), DW'(g), DW'(b)});
            end
         end
      end
   endtask

   // ---------------- drivers ----------------
   task automatic fill_random(input int rows, input int min_len, input int max_len);
      fr_rows = rows;
      for (int row = 0; row < rows; row++) begin
         fr_len[row] = $urandom_range(min_len, max_len);
         for (int c = 0; c < 8; c++) fr_pix[row][c] = $urandom_range(0, (1 << DW) - 1);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic drive_rows(input bit cap, input int mid_pat, input int stop_row,
                             input int start_row, input int gap_max);
      int gap;
      for (int row = 0; row < fr_rows; row++) begin
         for (int c = 0; c < fr_len[row]; c++) begin
            gap = (c == 0) ? 0 : int'($urandom_range(0, gap_max));
            for (int k = 0; k < gap; k++) begin
               pix.iLine_Valid = 1'b1; pix.iData_Valid = 1'b0; tick();
            end
            pix.iLine_Valid = 1'b1; pix.iData_Valid = 1'b1;
            pix.iData = DW'(fr_pix[row][c]);
            if (cap && (row % 2 == 1) && (c % 2 == 1) && (c < LW)) lat_q.push_back(cyc + 2);
            tick();
         end
         pix.iLine_Valid = 1'b0; pix.iData_Valid = 1'b0; tick();
         if (row == 0 && mid_pat >= 0) pattern = mid_pat[1:0];
         if (row == stop_row) pulse_stop();
         if (row == start_row) pulse_start();
      end
   endtask

   task automatic drive_frame(input int pat, input bit cap, input bit push, input int mid_pat,
                              input int stop_row, input int start_row, input int gap_max);
      pattern = pat[1:0];
      pix.iFrame_Valid = 1'b1; pix.iLine_Valid = 1'b0; pix.iData_Valid = 1'b0;
      tick();
      check("frame_start", frame_start, cap);
      if (cap) exp_count++;
      check("frame_count", frame_count, exp_count);
      if (cap) model_frame(pat, push);
      tick();
      drive_rows(cap, mid_pat, stop_row, start_row, gap_max);
      pix.iFrame_Valid = 1'b0;
      repeat (4) tick();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_red"}, pix.oRed, 0);
      check({tag, "_green"}, pix.oGreen, 0);
      check({tag, "_blue"}, pix.oBlue, 0);
      check({tag, "_valid"}, pix.oData_Valid, 0);
      check({tag, "_fstart"}, frame_start, 0);
      check({tag, "_count"}, frame_count, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_busy"}, busy, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int c0;
      vecs[0] = '{0, 100, 201, 302, 403, 100, 251, 403};
      vecs[1] = '{1, 100, 201, 302, 403, 201, 251, 302};
      vecs[2] = '{2, 100, 201, 302, 403, 302, 251, 201};
      vecs[3] = '{3, 100, 201, 302, 403, 403, 251, 100};
      vecs[4] = '{0, 1023, 1023, 1022, 1023, 1023, 1022, 1023};
      vecs[5] = '{1, 1023, 1023, 1022, 1023, 1023, 1023, 1022};
      vecs[6] = '{0, 0, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < LW; i++) line_mem[i] = 0;

      rst = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; single_shot = 1'b0; pattern = 2'd0;
      pix.iData = '0; pix.iData_Valid = 1'b0; pix.iFrame_Valid = 1'b0; pix.iLine_Valid = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      check("reset_state", state_dbg, IDLE);
      rst = 1'b0; enable = 1'b1;
      tick();

      // Pattern mapping table, continuous capture.
      pulse_start();
      check("armed_busy", busy, 1);
      foreach (vecs[i]) begin
         fr_rows = 2; fr_len[0] = 2; fr_len[1] = 2;
         fr_pix[0][0] = vecs[i].tl; fr_pix[0][1] = vecs[i].tr;
         fr_pix[1][0] = vecs[i].bl; fr_pix[1][1] = vecs[i].br;
         exp_q.push_back({DW'(vecs[i].r), DW'(vecs[i].g), DW'(vecs[i].b)});
         drive_frame(vecs[i].pat, 1, 0, -1, -1, -1, 0);
      end

      // 4x2 RGGB frame, then the same frame as BGGR with iPattern changed mid-frame.
      fr_rows = 2; fr_len[0] = 4; fr_len[1] = 4;
      fr_pix[0][0] = 100; fr_pix[0][1] = 200; fr_pix[0][2] = 100; fr_pix[0][3] = 200;
      fr_pix[1][0] = 300; fr_pix[1][1] = 400; fr_pix[1][2] = 300; fr_pix[1][3] = 400;
      repeat (2) exp_q.push_back({DW'(100), DW'(250), DW'(400)});
      drive_frame(0, 1, 0, -1, -1, -1, 0);
      repeat (2) exp_q.push_back({DW'(400), DW'(250), DW'(100)});
      drive_frame(3, 1, 0, 0, -1, -1, 1);

      // Graceful stop in frame 2 of a continuous run.
      c0 = exp_count;
      fill_random(2, 2, 4);
      drive_frame(1, 1, 1, -1, -1, -1, 1);
      fill_random(4, 4, 4);
      drive_frame(2, 1, 1, -1, 1, -1, 0);
      check("stop_idle", busy, 0);
      fill_random(2, 4, 4);
      drive_frame(0, 0, 0, -1, -1, -1, 0);
      check("stop_count", frame_count, c0 + 2);

      // Start and Stop together from IDLE; Stop while ARMED.
      start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
      check("start_stop_busy", busy, 0);
      check("start_stop_state", state_dbg, IDLE);
      pulse_start();
      check("armed_again", busy, 1);
      pulse_stop();
      check("stop_armed", busy, 0);

      // Single shot: one Start, three frames, only the first captured.
      single_shot = 1'b1;
      pulse_start();
      fill_random(2, 4, 4);
      drive_frame(3, 1, 1, -1, -1, -1, 0);
      check("single_idle", busy, 0);
      fill_random(2, 4, 4);
      drive_frame(0, 0, 0, -1, -1, -1, 0);
      drive_frame(1, 0, 0, -1, -1, -1, 0);
      single_shot = 1'b0;

      // Arming while iFrame_Valid is already high waits for the next frame.
      fill_random(2, 4, 4);
      drive_frame(0, 0, 0, -1, -1, 0, 0);
      check("armed_wait", busy, 1);
      fill_random(2, 4, 4);
      drive_frame(2, 1, 1, -1, -1, -1, 0);

      // Overflow: 6-pixel lines into a 4-deep line buffer.
      check("ovf_clear", overflow, 0);
      fr_rows = 2; fr_len[0] = 6; fr_len[1] = 6;
      for (int c = 0; c < 6; c++) begin
         fr_pix[0][c] = 10 * (c + 1);
         fr_pix[1][c] = 10 * (c + 7);
      end
      exp_q.push_back({DW'(10), DW'(45), DW'(80)});
      exp_q.push_back({DW'(30), DW'(65), DW'(100)});
      drive_frame(0, 1, 0, -1, -1, -1, 0);
      check("ovf_set", overflow, 1);
      fill_random(2, 2, 4);
      drive_frame(1, 1, 1, -1, -1, -1, 0);
      check("ovf_sticky", overflow, 1);

      // Reset mid-frame, released while iFrame_Valid stays high.
      pattern = 2'd0;
      pix.iFrame_Valid = 1'b1; tick();
      exp_count++;
      check("rst_fstart", frame_start, 1);
      tick();
      pix.iLine_Valid = 1'b1; pix.iData_Valid = 1'b1; pix.iData = DW'(11); tick();
      pix.iData = DW'(22); tick();
      line_mem[0] = 11; line_mem[1] = 22;
      pix.iData_Valid = 1'b0;
      rst = 1'b1;
      tick();
      check_all_zero("midrst");
      rst = 1'b0; exp_count = 0;
      tick();
      fill_random(2, 4, 4);
      drive_rows(0, -1, -1, -1, 0);
      pix.iFrame_Valid = 1'b0;
      repeat (3) tick();
      check("post_rst_busy", busy, 0);
      check("post_rst_count", frame_count, 0);
      pulse_start();
      fill_random(2, 4, 4);
      drive_frame(3, 1, 1, -1, -1, -1, 0);

      // Random frames in continuous mode.
      for (int n = 0; n < 30; n++) begin
         fill_random($urandom_range(1, 5), 1, 6);
         drive_frame($urandom_range(0, 3), 1, 1, -1, -1, -1, 2);
      end

      // Enable low clears all state including the sticky overflow.
      enable = 1'b0; tick();
      check("en_ovf", overflow, 0);
      check("en_count", frame_count, 0);
      check("en_busy", busy, 0);
      check("en_state", state_dbg, IDLE);
      enable = 1'b1;
      repeat (4) tick();

      check("exp_q_drained", exp_q.size(), 0);
      check("lat_q_drained", lat_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
